// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Holds opcode/funct constants, the FSM state enum, the datapath mux
// encodings, the registered control-vector struct and the DECODE dispatch
// helper.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
        S_MEM_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP,
        S_JUMP_R, S_JAL, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        B_RT = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_IMM_SH2 = 2'd3
    } alu_b_e;

    typedef enum logic [1:0] {
        DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2
    } mem_to_reg_e;

    // Registered portion of the control outputs. IR load and the
    // FETCH/BRANCH PC loads depend on same-cycle mem_ready/zero and are
    // qualified outside this vector.
    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        pc_write;
        pc_src_e     pc_src;
        logic        alu_src_a;
        alu_b_e      alu_src_b;
        alu_op_e     alu_op;
        logic        reg_write;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        busy;
        logic        trap;
    } ctrl_t;

    // DECODE dispatch: anything not recognised lands in TRAP.
    function automatic state_e decode_target(input logic [5:0] op,
                                             input logic [5:0] funct);
        state_e ns;
        ns = S_TRAP;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT)
                    ns = S_EXEC_R;
                else if (funct == FN_JR)
                    ns = S_JUMP_R;
            end
            OP_LW, OP_SW:     ns = S_MEM_ADDR;
            OP_ADDI, OP_XORI: ns = S_EXEC_I;
            OP_BEQ, OP_BNE:   ns = S_BRANCH;
            OP_J:             ns = S_JUMP;
            OP_JAL:           ns = S_JAL;
            default:          ns = S_TRAP;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/ctrl_outputs_lut.sv
// Pure combinational map from the FSM's next state (plus op/funct for the
// ALU operation) to the control vector that the FSM registers.
//   next_state_i : state being entered at the coming edge
//   op_i/funct_i : IR fields
//   ctrl_o       : control vector for that state
module ctrl_outputs_lut
    import mips_ctrl_pkg::*;
(
    input  state_e     next_state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o      = '0;
        ctrl_o.busy = (next_state_i != S_IDLE) && (next_state_i != S_TRAP);
        case (next_state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = B_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                ctrl_o.alu_src_b = B_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = B_RT;
                ctrl_o.alu_op    = (funct_i == FN_SUB) ? ALU_SUB :
                                   (funct_i == FN_SLT) ? ALU_SLT : ALU_ADD;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = DST_RD;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = B_IMM;
                ctrl_o.alu_op    = (op_i == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            S_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = B_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_LW_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = B_RT;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PC_BRANCH;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PC_JUMP;
            end
            S_JUMP_R: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PC_RS;
            end
            S_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = DST_R31;
                ctrl_o.mem_to_reg = WB_PC;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PC_JUMP;
            end
            S_TRAP: begin
                ctrl_o.trap = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the MIPS-subset datapath.
// Ports: clk/rst_n (async active-low), run, op/funct from the IR, ALU zero,
// mem_ready handshake; outputs are the per-cycle datapath strobes and mux
// selects, busy, sticky trap and the retired-instruction counter.
// Control outputs are registered from the next state so they line up with
// the state they belong to. The IR load and the FETCH/BRANCH PC loads are
// the exception: they must coincide with the cycle in which memory data or
// the ALU zero flag is actually present, so they are the registered state
// qualified by the live mem_ready/zero input.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             fetch_done;
    logic             take_br;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_target(op, funct);
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_LW_WB;
            S_MEM_WR:   if (mem_ready) retire = 1'b1;
            S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP, S_JUMP_R, S_JAL:
                        retire = 1'b1;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        // run is only consulted at instruction boundaries
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    ctrl_outputs_lut u_lut (
        .next_state_i (state_d),
        .op_i         (op),
        .funct_i      (funct),
        .ctrl_o       (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign fetch_done = (state_q == S_FETCH) && mem_ready;
    assign take_br    = (state_q == S_BRANCH) &&
                        (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero));

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign ir_write   = fetch_done;
    assign pc_write   = ctrl_q.pc_write | fetch_done | take_br;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign busy       = ctrl_q.busy;
    assign trap       = ctrl_q.trap;
    assign retired    = retired_q;

endmodule
